mpmc10_app_req_gen: RTL and testbench

//  Initiator side of the memory-app burst interface. Issues one app command per strip, starting at a strip-aligned base.

---
 rtl/mpmc10_pkg.sv | 28 ++
 rtl/mpmc10_strip_addr_step.sv | 21 ++
 rtl/mpmc10_app_req_gen.sv | 141 ++++++++++++++
 tb/tb_mpmc10_app_req_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 memory-app request path.
package mpmc10_pkg;

  localparam int unsigned APP_ADDR_W = 32;
  localparam int unsigned APP_CMD_W  = 3;
  localparam int unsigned STRIP_CNT_W = 6;

  localparam logic [APP_CMD_W-1:0]  APP_CMD_READ  = 3'b001;
  localparam logic [APP_CMD_W-1:0]  APP_CMD_WRITE = 3'b000;
  localparam logic [APP_ADDR_W-1:0] APP_ADDR_RST  = 32'h3FFF_FFFF;

  typedef enum logic [1:0] {
    AREQ_IDLE,
    AREQ_ISSUE,
    AREQ_DONE
  } mpmc10_areq_state_t;

  typedef struct packed {
    logic [APP_CMD_W-1:0]  cmd;
    logic [APP_ADDR_W-1:0] addr;
  } app_req_t;

  // Byte-offset bits inside one strip: 16-byte strips for WID=128, else 32-byte.
  function automatic int unsigned strip_lsb(input int unsigned wid);
    return (wid == 128) ? 4 : 5;
  endfunction

endpackage

// File: rtl/mpmc10_strip_addr_step.sv
// Combinational strip address helper: aligns a base down to a strip and steps to the next strip.
module mpmc10_strip_addr_step
  import mpmc10_pkg::*;
#(
  parameter int unsigned WID = 256
) (
  input  logic [31:0] addr,
  input  logic [31:0] base,
  output logic [31:0] next_addr_c,
  output logic [31:0] base_aligned_c
);

  localparam int unsigned LSB  = strip_lsb(WID);
  localparam logic [31:0] STEP = 32'd1 << LSB;
  localparam logic [31:0] MASK = ~(STEP - 32'd1);

  assign base_aligned_c = base & MASK;
  // Low bits forced to zero; the add wraps modulo 2^32.
  assign next_addr_c    = (addr & MASK) + STEP;

endmodule

// File: rtl/mpmc10_app_req_gen.sv
// Issues one DDR app command per strip for a burst of num_strips+1 strips.
// Optional stall timeout enabled with `define MPMC10_REQ_TIMEOUT_EN.
module mpmc10_app_req_gen
  import mpmc10_pkg::*;
#(
  parameter int unsigned WID     = 256,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [2:0]  cmd,
  input  logic [5:0]  num_strips,
  input  logic [31:0] addr_base,
  input  logic        app_rdy,
  output logic        app_en,
  output logic [2:0]  app_cmd,
  output logic [31:0] app_addr,
  output logic [5:0]  req_strip_cnt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (!(WID == 128 || WID == 256) || TIMEOUT < 1) begin : g_param_check
    $error("mpmc10_app_req_gen: WID must be 128 or 256 and TIMEOUT >= 1");
  end

  mpmc10_areq_state_t state_q, state_d;
  app_req_t           req_q, req_d;
  logic               en_d, busy_d, done_d, err_d;
  logic [5:0]         cnt_d, ns_q, ns_d;
  logic [31:0]        next_addr, base_aligned;
  logic               accept;

`ifdef MPMC10_REQ_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  mpmc10_strip_addr_step #(
    .WID(WID)
  ) u_step (
    .addr          (req_q.addr),
    .base          (addr_base),
    .next_addr_c   (next_addr),
    .base_aligned_c(base_aligned)
  );

  assign accept   = app_en && app_rdy;
  assign app_cmd  = req_q.cmd;
  assign app_addr = req_q.addr;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    en_d    = app_en;
    cnt_d   = req_strip_cnt;
    ns_d    = ns_q;
    done_d  = 1'b0;
    err_d   = err;
`ifdef MPMC10_REQ_TIMEOUT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      AREQ_IDLE: begin
        if (go) begin
          state_d    = AREQ_ISSUE;
          req_d.addr = base_aligned;
          req_d.cmd  = cmd;
          cnt_d      = 6'd0;
          ns_d       = num_strips;
          en_d       = 1'b1;
          err_d      = 1'b0;
`ifdef MPMC10_REQ_TIMEOUT_EN
          stall_d    = '0;
`endif
        end
      end
      AREQ_ISSUE: begin
        if (accept) begin
`ifdef MPMC10_REQ_TIMEOUT_EN
          stall_d = '0;
`endif
          if (req_strip_cnt == ns_q) begin
            state_d = AREQ_DONE;
            en_d    = 1'b0;
            cnt_d   = ns_q + 6'd1;
            done_d  = 1'b1;
          end else begin
            cnt_d      = req_strip_cnt + 6'd1;
            req_d.addr = next_addr;
          end
        end
`ifdef MPMC10_REQ_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          state_d = AREQ_IDLE;
          en_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      AREQ_DONE: state_d = AREQ_IDLE;
      default:   state_d = AREQ_IDLE;
    endcase
    busy_d = (state_d != AREQ_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= AREQ_IDLE;
      req_q.cmd     <= APP_CMD_READ;
      req_q.addr    <= APP_ADDR_RST;
      app_en        <= 1'b0;
      req_strip_cnt <= 6'd0;
      ns_q          <= 6'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
`ifdef MPMC10_REQ_TIMEOUT_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      app_en        <= en_d;
      req_strip_cnt <= cnt_d;
      ns_q          <= ns_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
`ifdef MPMC10_REQ_TIMEOUT_EN
      stall_q       <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_mpmc10_app_req_gen.sv
// Randomized bench for mpmc10_app_req_gen; runs a WID=256 and a WID=128 instance in lockstep.
module tb_mpmc10_app_req_gen;

  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] WR = 3'b000;

  logic        clk = 1'b0;
  logic        rst, go, app_rdy;
  logic [2:0]  cmd;
  logic [5:0]  num_strips;
  logic [31:0] addr_base;

  logic        en_a, busy_a, done_a, err_a, en_b, busy_b, done_b, err_b;
  logic [2:0]  cmd_a, cmd_b;
  logic [31:0] addr_a, addr_b;
  logic [5:0]  cnt_a, cnt_b;
  logic [12:0] ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl_a = {en_a, cmd_a, cnt_a, busy_a, done_a, err_a};
  assign ctl_b = {en_b, cmd_b, cnt_b, busy_b, done_b, err_b};

  mpmc10_app_req_gen #(.WID(256), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst(rst), .go(go), .cmd(cmd), .num_strips(num_strips), .addr_base(addr_base),
    .app_rdy(app_rdy), .app_en(en_a), .app_cmd(cmd_a), .app_addr(addr_a),
    .req_strip_cnt(cnt_a), .busy(busy_a), .done(done_a), .err(err_a));

  mpmc10_app_req_gen #(.WID(128), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst), .go(go), .cmd(cmd), .num_strips(num_strips), .addr_base(addr_base),
    .app_rdy(app_rdy), .app_en(en_b), .app_cmd(cmd_b), .app_addr(addr_b),
    .req_strip_cnt(cnt_b), .busy(busy_b), .done(done_b), .err(err_b));

  // Address of strip k: base rounded down to a stride multiple, plus k strides, modulo 2^32.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [31:0] stride, input int k);
    return base - (base % stride) + 32'(k) * stride;
  endfunction

  // One full burst with a model of accepted commands; abort_after>=0 returns after that many accepts.
  task automatic run_burst(input string name, input logic [2:0] c, input logic [5:0] ns,
                           input logic [31:0] base, input int stall_pct, input int stall_k,
                           input int stall_len, input int abort_after);
    int k = 0;
    int held = 0;
    int guard = 0;
    logic rdy;
    logic [12:0] exp;
    logic [31:0] ea, eb;
    @(negedge clk);
    go = 1'b1; cmd = c; num_strips = ns; addr_base = base; app_rdy = 1'b0;
    @(negedge clk);
    go = 1'b0;
    cmd = 3'($urandom); num_strips = 6'($urandom); addr_base = $urandom;
    forever begin
      exp = {1'b1, c, 6'(k), 1'b1, 1'b0, 1'b0};
      ea = exp_addr(base, 32'd32, k);
      eb = exp_addr(base, 32'd16, k);
      checks++;
      if (ctl_a !== exp || ctl_b !== exp || addr_a !== ea || addr_b !== eb) begin
        errors++;
        $display("FAIL %s issue k=%0d: ctl=%h/%h addr=%h/%h expected ctl=%h addr=%h/%h",
                 name, k, ctl_a, ctl_b, addr_a, addr_b, exp, ea, eb);
      end
      if (abort_after >= 0 && k == abort_after) return;
      rdy = ($urandom_range(99) >= 32'(stall_pct));
      if (k == stall_k && held < stall_len) begin
        rdy = 1'b0;
        held++;
      end
      app_rdy = rdy;
      go = 1'($urandom);
      if (rdy) k++;
      @(negedge clk);
      if (k == int'(ns) + 1) break;
      if (++guard > 5000) begin
        checks++; errors++;
        $display("FAIL %s: burst did not complete, accepts=%0d expected %0d", name, k, int'(ns) + 1);
        return;
      end
    end
    app_rdy = 1'b0;
    go = 1'b1;
    exp = {1'b0, c, 6'(k), 1'b1, 1'b1, 1'b0};
    checks++;
    if (ctl_a !== exp || ctl_b !== exp) begin
      errors++;
      $display("FAIL %s done cycle: ctl=%h/%h expected %h", name, ctl_a, ctl_b, exp);
    end
    @(negedge clk);
    go = 1'b0;
    exp = {1'b0, c, 6'(k), 1'b0, 1'b0, 1'b0};
    checks++;
    if (ctl_a !== exp || ctl_b !== exp) begin
      errors++;
      $display("FAIL %s idle after done: ctl=%h/%h expected %h", name, ctl_a, ctl_b, exp);
    end
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    rst = 1'b1; go = 1'b0; app_rdy = 1'b0; cmd = WR; num_strips = 6'd5; addr_base = 32'h1234;
    repeat (3) @(negedge clk);
    exp = {1'b0, RD, 6'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (ctl_a !== exp || ctl_b !== exp || addr_a !== 32'h3FFF_FFFF || addr_b !== 32'h3FFF_FFFF) begin
      errors++;
      $display("FAIL reset: ctl=%h/%h addr=%h/%h expected ctl=%h addr=3fffffff", ctl_a, ctl_b, addr_a, addr_b, exp);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_burst("basic",     RD, 6'd3, 32'h0000_1234, 0, -1, 0, -1);
    run_burst("stall2nd",  RD, 6'd3, 32'h0000_1234, 0,  1, 5, -1);
    run_burst("single_wr", WR, 6'd0, 32'h0000_1234, 0, -1, 0, -1);
    run_burst("addr_wrap", RD, 6'd1, 32'hFFFF_FFF8, 0, -1, 0, -1);
  endtask

  task automatic test_reset_midburst();
    logic [12:0] exp;
    run_burst("rst_mid", WR, 6'd7, 32'h0000_8000, 0, -1, 0, 2);
    rst = 1'b1; go = 1'b0; app_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0; app_rdy = 1'b0;
    exp = {1'b0, RD, 6'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (ctl_a !== exp || ctl_b !== exp || addr_a !== 32'h3FFF_FFFF || addr_b !== 32'h3FFF_FFFF) begin
      errors++;
      $display("FAIL rst_mid reset: ctl=%h/%h addr=%h/%h expected ctl=%h addr=3fffffff", ctl_a, ctl_b, addr_a, addr_b, exp);
    end
    run_burst("rst_restart", RD, 6'd2, 32'h0000_4444, 20, -1, 0, -1);
  endtask

  task automatic test_max_strips();
    run_burst("max_strips", WR, 6'd63, $urandom, 25, -1, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_burst("random", ($urandom_range(1) != 0) ? RD : WR, 6'($urandom_range(15)), $urandom, 30, -1, 0, -1);
  endtask

  task automatic test_stall_timeout();
    logic [12:0] exp;
    @(negedge clk);
    go = 1'b1; cmd = RD; num_strips = 6'd0; addr_base = 32'h100; app_rdy = 1'b0;
    @(negedge clk);
    go = 1'b0;
`ifdef MPMC10_REQ_TIMEOUT_EN
    exp = {1'b1, RD, 6'd0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (ctl_a !== exp || ctl_b !== exp) begin
        errors++;
        $display("FAIL timeout stall %0d: ctl=%h/%h expected %h", i, ctl_a, ctl_b, exp);
      end
      @(negedge clk);
    end
    exp = {1'b0, RD, 6'd0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctl_a !== exp || ctl_b !== exp) begin
        errors++;
        $display("FAIL timeout expired %0d: ctl=%h/%h expected %h", i, ctl_a, ctl_b, exp);
      end
      @(negedge clk);
    end
    run_burst("after_timeout", WR, 6'd1, 32'h200, 0, -1, 0, -1);
`else
    exp = {1'b1, RD, 6'd0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (ctl_a !== exp || ctl_b !== exp) begin
        errors++;
        $display("FAIL no_timeout stall %0d: ctl=%h/%h expected %h", i, ctl_a, ctl_b, exp);
      end
      @(negedge clk);
    end
    app_rdy = 1'b1;
    @(negedge clk);
    app_rdy = 1'b0;
    exp = {1'b0, RD, 6'd1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (ctl_a !== exp || ctl_b !== exp) begin
      errors++;
      $display("FAIL no_timeout release: ctl=%h/%h expected %h", ctl_a, ctl_b, exp);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midburst();
    test_max_strips();
    test_random();
    test_stall_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
